lcd_seq_ctl: RTL

Parametrised start/done sequencer for the SPI LCD subsystem. It drives an ordered chain of N sub-modules (e.g. init, clear, draw) through one level-held start/done handshake per stage. It can halt after the last stage or loop back to a chosen stage for continuous refresh, and it can restart on request. A per-stage watchdog detects a hung sub-module and latches an error.

---
 rtl/lcd_seq_ctl.sv | 93 +++++++++
 1 files changed

// File: rtl/lcd_seq_ctl.sv
// Start/done sequencer for the SPI LCD sub-module chain (init, clear, draw, ...).
// Supports halting or looping after the last stage, redraw restart, and a per-stage watchdog.
module lcd_seq_ctl #(
    parameter int unsigned N_STAGES  = 2,
    parameter int unsigned LOOP_FROM = 1,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                Loop_En,
    input  logic                Redraw_Sig,
    input  logic [N_STAGES-1:0] Done_Sig,
    output logic [N_STAGES-1:0] Start_Sig,
    output logic                Busy,
    output logic                Seq_Done,
    output logic                Err_Sig,
    output logic [2:0]          Err_Stage,
    output logic [2:0]          Cur_Stage
);

    typedef enum logic [1:0] {StRun, StDone, StErr} state_e;

    state_e               state;
    logic [2:0]           idx;
    logic [TIMEOUT_W-1:0] wd;
    logic [N_STAGES-1:0]  sel;
    logic                 cur_start;
    logic                 cur_done;

    // One-hot decode of the stage index; avoids a variable bit-select wider than the vector.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            sel[i] = (idx == 3'(i));
        end
    end

    assign cur_start = |(Start_Sig & sel);
    assign cur_done  = |(Done_Sig & sel);
    assign Busy      = (state == StRun);
    assign Cur_Stage = idx;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= StRun;
            idx       <= 3'd0;
            wd        <= '0;
            Start_Sig <= '0;
            Seq_Done  <= 1'b0;
            Err_Sig   <= 1'b0;
            Err_Stage <= 3'd0;
        end else begin
            unique case (state)
                StRun: begin
                    if (!cur_start) begin
                        // Done is not looked at here, so a stale done cannot skip a stage.
                        Start_Sig <= sel;
                        wd        <= '0;
                    end else if (cur_done) begin
                        Start_Sig <= '0;
                        if (idx != 3'(N_STAGES - 1)) begin
                            idx <= idx + 3'd1;
                        end else if (Loop_En) begin
                            idx <= 3'(LOOP_FROM);
                        end else begin
                            state    <= StDone;
                            Seq_Done <= 1'b1;
                        end
                    end else if (&wd) begin
                        state     <= StErr;
                        Start_Sig <= '0;
                        Err_Sig   <= 1'b1;
                        Err_Stage <= idx;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                StDone: begin
                    Start_Sig <= '0;
                    if (Redraw_Sig) begin
                        idx      <= 3'(LOOP_FROM);
                        state    <= StRun;
                        Seq_Done <= 1'b0;
                    end
                end
                default: begin
                    Start_Sig <= '0;
                end
            endcase
        end
    end

endmodule
